// File: rtl/mcm_pkg.sv
// ---------------------------------------------------------------------------
// mcm_pkg
// Shared definitions for the packed-MCM unpacker:
//   state_e    - decoder FSM states (IDLE, EMIT)
//   DEF_P_W    - default packed word width (DSP P output)
//   DEF_SLOT_W - default slot pitch / signed product width
//   idx_width  - field-index width helper, never narrower than 1 bit
// ---------------------------------------------------------------------------
package mcm_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } state_e;

  localparam int DEF_P_W    = 48;
  localparam int DEF_SLOT_W = 12;

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mcm_unpack_sat.sv
// ---------------------------------------------------------------------------
// mcm_unpack_sat
// Narrows one signed SLOT_W field to OUT_W bits.
//   MCM_UNPACK_SAT_EN defined   : clamp to the signed OUT_W range, flag ovf_o
//   MCM_UNPACK_SAT_EN undefined : plain truncation, ovf_o tied 0
// Ports:
//   field_i  in  SLOT_W  signed field value
//   data_o   out OUT_W   narrowed value
//   ovf_o    out 1       clamping occurred for this field
// ---------------------------------------------------------------------------
module mcm_unpack_sat #(
  parameter int SLOT_W = 12,
  parameter int OUT_W  = 12
) (
  input  logic signed [SLOT_W-1:0] field_i,
  output logic signed [OUT_W-1:0]  data_o,
  output logic                     ovf_o
);

  logic signed [SLOT_W-1:0] sel;

`ifdef MCM_UNPACK_SAT_EN
  localparam int MAX_I = (1 << (OUT_W - 1)) - 1;
  localparam logic signed [SLOT_W-1:0] MAX_V = SLOT_W'(MAX_I);
  // -2^(OUT_W-1) is the bitwise complement of 2^(OUT_W-1)-1.
  localparam logic signed [SLOT_W-1:0] MIN_V = ~MAX_V;

  always_comb begin
    sel   = field_i;
    ovf_o = 1'b0;
    if (field_i > MAX_V) begin
      sel   = MAX_V;
      ovf_o = 1'b1;
    end else if (field_i < MIN_V) begin
      sel   = MIN_V;
      ovf_o = 1'b1;
    end
  end
`else
  assign sel   = field_i;
  assign ovf_o = 1'b0;
`endif

  assign data_o = sel[OUT_W-1:0];

  // Bits above OUT_W are deliberately dropped after the clamp/truncate.
  generate
    if (OUT_W < SLOT_W) begin : g_drop_hi
      logic unused_hi;
      assign unused_hi = ^sel[SLOT_W-1:OUT_W];
    end
  endgenerate

endmodule

// File: rtl/mcm_unpack.sv
// ---------------------------------------------------------------------------
// mcm_unpack
// Stream decoder for a packed multiple-constant-multiplication DSP word.
// A P_W-bit word holding NUM_FIELDS signed products (slot pitch SLOT_W) is
// accepted over in_valid/in_ready and emitted one product per out handshake,
// lowest slot first, with the borrow left by negative lower fields undone.
// Optional build macro: MCM_UNPACK_SAT_EN (saturate to OUT_W and flag ovf
// instead of truncating).
// Ports:
//   clk        in   1      rising-edge clock
//   rst_n      in   1      asynchronous active-low reset
//   in_valid   in   1      in_p is valid
//   in_ready   out  1      word accepted this cycle
//   in_p       in   P_W    packed word
//   out_valid  out  1      out_data is valid
//   out_ready  in   1      consumer accepts out_data
//   out_data   out  OUT_W  signed decoded product
//   out_idx    out  IDX_W  slot index of out_data
//   out_last   out  1      final field of the word
//   ovf        out  1      current field was clamped
// ---------------------------------------------------------------------------
module mcm_unpack
  import mcm_pkg::*;
#(
  parameter int P_W        = DEF_P_W,
  parameter int SLOT_W     = DEF_SLOT_W,
  parameter int NUM_FIELDS = 2,
  parameter int OUT_W      = 12,
  parameter int IDX_W      = idx_width(NUM_FIELDS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [P_W-1:0]          in_p,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic [IDX_W-1:0]        out_idx,
  output logic                    out_last,
  output logic                    ovf
);

  state_e                   state_q;
  logic signed [P_W-1:0]    r_q;
  logic [IDX_W-1:0]         idx_q;

  logic signed [SLOT_W-1:0] field;
  logic signed [P_W-1:0]    r_adv_d;
  logic                     fire;
  logic                     sat_ovf;

  // Current field is always the lowest slot of the residual.
  assign field = r_q[SLOT_W-1:0];

  // Removing the sign-extended field first turns any borrow it caused into
  // an exact carry back into the upper slots; the low SLOT_W bits become
  // zero and the arithmetic shift exposes the next field.
  assign r_adv_d = (r_q - P_W'(field)) >>> SLOT_W;

  assign out_valid = (state_q == EMIT);
  assign out_idx   = idx_q;
  assign out_last  = (state_q == EMIT) && (idx_q == IDX_W'(NUM_FIELDS - 1));
  assign fire      = out_valid && out_ready;
  assign in_ready  = rst_n && ((state_q == IDLE) || (fire && out_last));

  mcm_unpack_sat #(
    .SLOT_W (SLOT_W),
    .OUT_W  (OUT_W)
  ) u_sat (
    .field_i (field),
    .data_o  (out_data),
    .ovf_o   (sat_ovf)
  );

  assign ovf = out_valid && sat_ovf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      r_q     <= '0;
      idx_q   <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            r_q     <= in_p;
            idx_q   <= '0;
            state_q <= EMIT;
          end
        end
        EMIT: begin
          if (out_ready) begin
            if (!out_last) begin
              r_q   <= r_adv_d;
              idx_q <= idx_q + 1'b1;
            end else if (in_valid) begin
              // Chain straight into the next word: no idle bubble.
              r_q   <= in_p;
              idx_q <= '0;
            end else begin
              // Clear the residual so idle outputs read back as zero.
              r_q     <= '0;
              idx_q   <= '0;
              state_q <= IDLE;
            end
          end
        end
        default: begin
          state_q <= IDLE;
          r_q     <= '0;
          idx_q   <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mcm_unpack.sv
// ---------------------------------------------------------------------------
// tb_mcm_unpack
// Directed-vector bench for mcm_unpack. A default instance (OUT_W=12) and an
// OUT_W=8 instance share the same stimulus; expected values for the narrow
// instance follow MCM_UNPACK_SAT_EN (clamp) or its absence (truncate).
// ---------------------------------------------------------------------------
module tb_mcm_unpack;

`ifdef MCM_UNPACK_SAT_EN
  localparam bit SAT_EN = 1'b1;
`else
  localparam bit SAT_EN = 1'b0;
`endif

  localparam logic [47:0] W_A = 48'h00000000_4FFD;   // v0=-3,  v1=5
  localparam logic [47:0] W_B = -48'sd331677;        // v0=99,  v1=-81
  localparam logic [47:0] W_C = -48'sd4097;          // v0=-1,  v1=-1

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n;
  logic        in_valid;
  logic        out_ready;
  logic [47:0] in_p;

  logic              in_ready, out_valid, out_last, ovf;
  logic signed [11:0] out_data;
  logic [0:0]        out_idx;

  logic              in_ready8, out_valid8, out_last8, ovf8;
  logic signed [7:0] out_data8;
  logic [0:0]        out_idx8;

  int err_cnt = 0;
  int chk_cnt = 0;

  mcm_unpack dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_p      (in_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_idx   (out_idx),
    .out_last  (out_last),
    .ovf       (ovf)
  );

  mcm_unpack #(.OUT_W(8)) dut8 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready8),
    .in_p      (in_p),
    .out_valid (out_valid8),
    .out_ready (out_ready),
    .out_data  (out_data8),
    .out_idx   (out_idx8),
    .out_last  (out_last8),
    .ovf       (ovf8)
  );

  task automatic check(input string tag, input logic signed [31:0] got,
                       input logic signed [31:0] exp);
    chk_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // One isolated word with out_ready high. e* are the 12-bit results,
  // s*/t* the 8-bit results with clamping / truncation respectively.
  task automatic run_word(input logic [47:0] p, input int e0, input int e1,
                          input int s0, input int t0, input int s1, input int t1);
    @(negedge clk);
    in_p      = p;
    in_valid  = 1'b1;
    out_ready = 1'b1;
    check("idle_in_ready", in_ready, 1);
    @(negedge clk);
    in_valid = 1'b0;
    check("f0_valid", out_valid, 1);
    check("f0_data", out_data, e0);
    check("f0_idx", out_idx, 0);
    check("f0_last", out_last, 0);
    check("f0_ovf", ovf, 0);
    check("f0_in_ready", in_ready, 0);
    check("f0_valid8", out_valid8, 1);
    check("f0_data8", out_data8, SAT_EN ? s0 : t0);
    check("f0_ovf8", ovf8, (SAT_EN && (s0 != e0)) ? 1 : 0);
    @(negedge clk);
    check("f1_valid", out_valid, 1);
    check("f1_data", out_data, e1);
    check("f1_idx", out_idx, 1);
    check("f1_last", out_last, 1);
    check("f1_in_ready", in_ready, 1);
    check("f1_data8", out_data8, SAT_EN ? s1 : t1);
    check("f1_ovf8", ovf8, (SAT_EN && (s1 != e1)) ? 1 : 0);
    @(negedge clk);
    check("done_valid", out_valid, 0);
    check("done_data", out_data, 0);
    $display("word %h -> %0d, %0d (narrow %0d, %0d)", p, e0, e1,
             SAT_EN ? s0 : t0, SAT_EN ? s1 : t1);
  endtask

  initial begin
    logic [47:0] words [3];
    int          exp_b2b [6];
    words   = '{W_A, W_B, W_C};
    exp_b2b = '{-3, 5, 99, -81, -1, -1};

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_p      = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_idx", out_idx, 0);
    check("rst_last", out_last, 0);
    check("rst_ovf", ovf, 0);
    check("rst_in_ready", in_ready, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);

    // Isolated words
    run_word(W_A, -3, 5, -3, -3, 5, 5);
    run_word(W_B, 99, -81, 99, 99, -81, -81);
    run_word(W_C, -1, -1, -1, -1, -1, -1);
    run_word(48'hABCD_EF00_4FFD, -3, 5, -3, -3, 5, 5);     // junk above slot 1
    run_word(48'h0000_007F_E800, -2048, 2047, -128, 0, 127, -1);
    run_word(48'h0000_0000_00C8, 200, 0, 127, -56, 0, 0);
    run_word(48'h0000_0000_0ED4, -300, 1, -128, -44, 1, 1);

    // Back-to-back words, no bubbles
    @(negedge clk);
    in_p      = words[0];
    in_valid  = 1'b1;
    out_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check("b2b_valid", out_valid, 1);
      check("b2b_data", out_data, exp_b2b[k]);
      check("b2b_idx", out_idx, k % 2);
      check("b2b_last", out_last, k % 2);
      check("b2b_in_ready", in_ready, k % 2);
      if (k % 2 == 0) begin
        if (k / 2 + 1 < 3) in_p = words[k / 2 + 1];
        else in_valid = 1'b0;
      end
    end
    $display("b2b: 3 words streamed");
    @(negedge clk);
    check("b2b_end_valid", out_valid, 0);

    // Back-pressure on field 0
    in_p      = W_A;
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    in_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      check("stall_valid", out_valid, 1);
      check("stall_data", out_data, -3);
      check("stall_idx", out_idx, 0);
      check("stall_in_ready", in_ready, 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    check("stall_rel_data", out_data, -3);
    @(negedge clk);
    check("stall_f1_data", out_data, 5);
    check("stall_f1_last", out_last, 1);
    @(negedge clk);
    check("stall_end_valid", out_valid, 0);
    $display("stall: word %h held 3 cycles", W_A);

    // Reset during field 1
    in_p     = W_B;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    check("mid_f0_data", out_data, 99);
    @(negedge clk);
    check("mid_f1_idx", out_idx, 1);
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", out_valid, 0);
    check("mid_rst_data", out_data, 0);
    check("mid_rst_idx", out_idx, 0);
    check("mid_rst_last", out_last, 0);
    check("mid_rst_in_ready", in_ready, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("mid_rel_in_ready", in_ready, 1);
    check("mid_rel_valid", out_valid, 0);
    $display("reset mid-word: word %h discarded", W_B);
    run_word(W_A, -3, 5, -3, -3, 5, 5);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
